rvc_read_arbiter: RTL

RVC_READ_ARBITER -- requirements
Module: rvc_read_arbiter

---
 rtl/rvc_read_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rvc_read_arbiter.sv
// Two-requester AXI read-channel arbiter: round-robin grant, one burst in flight,
// with a sticky flag for RLAST / beat-count disagreement from the shared master.
module rvc_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 (instruction port)
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [LEN_W-1:0]  s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [ID_W-1:0]   s0_rid,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  // requester 1 (data port)
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [LEN_W-1:0]  s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [ID_W-1:0]   s1_rid,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  // shared master
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W-1:0]   m_arid,
  output logic [LEN_W-1:0]  m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  // status
  output logic              grant,
  output logic              busy,
  output logic              proto_err,
  output logic [1:0]        fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and payload is held while valid is unacknowledged.
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               prio_q, prio_d;
  logic               err_q, err_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W:0]     cnt_q, cnt_d;

  logic               sel_arvalid;
  logic [LEN_W-1:0]   sel_arlen;
  logic               sel_rready;

  assign sel_arvalid = grant_q ? s1_arvalid : s0_arvalid;
  assign sel_arlen   = grant_q ? s1_arlen   : s0_arlen;
  assign sel_rready  = grant_q ? s1_rready  : s0_rready;

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign proto_err = err_q;
  assign fsm_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      err_q   <= err_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    err_d      = err_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_arid     = '0;
    m_arlen    = '0;
    m_arsize   = '0;
    m_arburst  = '0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s0_rdata   = '0;
    s0_rid     = '0;
    s0_rresp   = '0;
    s0_rlast   = 1'b0;
    s1_rvalid  = 1'b0;
    s1_rdata   = '0;
    s1_rid     = '0;
    s1_rresp   = '0;
    s1_rlast   = 1'b0;

    case (state_q)
      IDLE: begin
        // prio names the requester that wins a tie; a lone requester always wins
        if (s0_arvalid || s1_arvalid) begin
          grant_d = (s0_arvalid && s1_arvalid) ? prio_q : s1_arvalid;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_arvalid  = sel_arvalid;
        m_araddr   = grant_q ? s1_araddr  : s0_araddr;
        m_arid     = grant_q ? s1_arid    : s0_arid;
        m_arlen    = grant_q ? s1_arlen   : s0_arlen;
        m_arsize   = grant_q ? s1_arsize  : s0_arsize;
        m_arburst  = grant_q ? s1_arburst : s0_arburst;
        s0_arready = !grant_q && m_arready;
        s1_arready = grant_q && m_arready;
        if (!sel_arvalid) begin
          state_d = IDLE;
        end else if (m_arready) begin
          state_d = DATA;
          len_d   = sel_arlen;
          cnt_d   = '0;
        end
      end
      DATA: begin
        m_rready = sel_rready;
        if (grant_q) begin
          s1_rvalid = m_rvalid;
          s1_rdata  = m_rdata;
          s1_rid    = m_rid;
          s1_rresp  = m_rresp;
          s1_rlast  = m_rlast;
        end else begin
          s0_rvalid = m_rvalid;
          s0_rdata  = m_rdata;
          s0_rid    = m_rid;
          s0_rresp  = m_rresp;
          s0_rlast  = m_rlast;
        end
        if (m_rvalid && sel_rready) begin
          cnt_d = cnt_q + 1'b1;
          // last must coincide exactly with beat number len; the burst still ends on rlast
          if (m_rlast != (cnt_q == {1'b0, len_q})) err_d = 1'b1;
          if (m_rlast) begin
            state_d = IDLE;
            prio_d  = ~grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
